// File: rtl/w_stage_grf.sv
// Writeback stage: decodes the W-stage instruction, commits to a 32x32 register file,
// serves two D-stage read ports, and counts retired instructions.
// Optional W->D same-cycle bypass on the read ports: define GRF_BYPASS_EN.

module w_stage_grf #(
    parameter int unsigned NREG            = 32,
    parameter int unsigned RESET_PC_OFFSET = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrIn,
    input  logic [31:0] PCin,
    input  logic [31:0] ALUin,
    input  logic [31:0] DMin,
    input  logic [31:0] EXTin,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [4:0]  WA,
    output logic [31:0] WD,
    output logic        WE,
    output logic [31:0] RetireCnt
);

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned OPW = 6;

    localparam logic [OPW-1:0] OP_SPECIAL = 6'h00;
    localparam logic [OPW-1:0] OP_JAL     = 6'h03;
    localparam logic [OPW-1:0] OP_ORI     = 6'h0d;
    localparam logic [OPW-1:0] OP_LUI     = 6'h0f;
    localparam logic [OPW-1:0] OP_LW      = 6'h23;
    localparam logic [OPW-1:0] FN_ADDU    = 6'h21;
    localparam logic [OPW-1:0] FN_SUBU    = 6'h23;
    localparam logic [AW-1:0]  RA_IDX     = 5'd31;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    logic [OPW-1:0] op;
    logic [OPW-1:0] fn;
    logic [AW-1:0]  rt;
    logic [AW-1:0]  rd;
    wb_req_t        dec;
    logic           wr_ok;

    assign op = InstrIn[31:26];
    assign fn = InstrIn[5:0];
    assign rt = InstrIn[20:16];
    assign rd = InstrIn[15:11];

    // Instruction class -> raw write request (before the $0 filter)
    always_comb begin
        dec = '0;
        case (op)
            OP_SPECIAL: begin
                if (fn == FN_ADDU || fn == FN_SUBU) begin
                    dec = '{wr: 1'b1, addr: rd, data: ALUin};
                end
            end
            OP_ORI:  dec = '{wr: 1'b1, addr: rt, data: ALUin};
            OP_LW:   dec = '{wr: 1'b1, addr: rt, data: DMin};
            OP_LUI:  dec = '{wr: 1'b1, addr: rt, data: EXTin};
            OP_JAL:  dec = '{wr: 1'b1, addr: RA_IDX, data: PCin + DW'(RESET_PC_OFFSET)};
            default: dec = '0;
        endcase
    end

    // $0 and out-of-range targets collapse to "no write"
    assign wr_ok = dec.wr && (dec.addr != '0) && (32'(dec.addr) < NREG);
    assign WE    = wr_ok;
    assign WA    = wr_ok ? dec.addr : '0;
    assign WD    = wr_ok ? dec.data : '0;

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (WE) begin
            regs[WA] <= WD;
        end
    end

    logic [DW-1:0] rd1_stored;
    logic [DW-1:0] rd2_stored;

    // Stored-value reads; address 0 is hardwired to zero
    always_comb begin
        rd1_stored = '0;
        rd2_stored = '0;
        if (A1 != '0 && 32'(A1) < NREG) begin
            rd1_stored = regs[A1];
        end
        if (A2 != '0 && 32'(A2) < NREG) begin
            rd2_stored = regs[A2];
        end
    end

`ifdef GRF_BYPASS_EN
    // Same-cycle W->D forward; held off during reset so the ports read zero
    always_comb begin
        RD1 = rd1_stored;
        RD2 = rd2_stored;
        if (reset && WE && (A1 == WA)) begin
            RD1 = WD;
        end
        if (reset && WE && (A2 == WA)) begin
            RD2 = WD;
        end
    end
`else
    assign RD1 = rd1_stored;
    assign RD2 = rd2_stored;
`endif

    logic [DW-1:0] retire_cnt;

    // Every non-bubble instruction retires, writing or not; wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
        end else if (InstrIn != '0) begin
            retire_cnt <= retire_cnt + DW'(1);
        end
    end

    assign RetireCnt = retire_cnt;

endmodule
